// File: rtl/multi_clock_divider.sv
// Bank of independent 50%-duty clock dividers with shadowed, glitch-free half-period updates.
// Optional CLKDIV_SYNC_EN adds a global sync input that phase-aligns all channels.

module multi_clock_divider_lane #(
  parameter int CNT_W    = 32,
  parameter int DIV_INIT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);
  localparam logic [CNT_W-1:0] H_RST = (DIV_INIT == 0) ? CNT_W'(1) : CNT_W'(DIV_INIT);

  logic [CNT_W-1:0] r_h, r_s, r_c;
  logic             r_clk, r_tick, r_pend;
  logic             w_tc;
  logic [CNT_W-1:0] w_val;

  assign w_tc  = (r_c == r_h - CNT_W'(1));
  assign w_val = (i_val == '0) ? CNT_W'(1) : i_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h    <= H_RST;
      r_s    <= H_RST;
      r_c    <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_sync) begin
        r_c   <= '0;
        r_clk <= 1'b0;
        if (r_pend) r_h <= r_s;
        r_pend <= 1'b0;
      end else if (i_en) begin
        if (w_tc) begin
          r_c    <= '0;
          r_clk  <= ~r_clk;
          r_tick <= 1'b1;
          if (r_pend) begin
            r_h    <= r_s;
            r_pend <= 1'b0;
          end
        end else begin
          r_c <= r_c + CNT_W'(1);
        end
      end else if (r_pend) begin
        // idle channel: take the new period immediately and restart the half-period
        r_h    <= r_s;
        r_c    <= '0;
        r_pend <= 1'b0;
      end
      // a write in the same cycle lands after any application of the old shadow
      if (i_wr) begin
        r_s    <= w_val;
        r_pend <= 1'b1;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = r_pend;
endmodule

module multi_clock_divider #(
  parameter int  NUM_CH   = 4,
  parameter int  CNT_W    = 32,
  parameter int  DIV_INIT = 50000000,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pend
);
  logic              w_sync;
  logic [NUM_CH-1:0] w_wr;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  // out-of-range selects match no lane, so the write is dropped
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign w_wr[g] = div_wr && (div_sel == SEL_W'(g));

    multi_clock_divider_lane #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (en[g]),
      .i_sync (w_sync),
      .i_wr   (w_wr[g]),
      .i_val  (div_val),
      .o_clk  (clk_out[g]),
      .o_tick (tick[g]),
      .o_pend (div_pend[g])
    );
  end
endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench: stimulus queues hand-computed per-channel outputs tagged with a cycle number;
// a negedge monitor compares every entry due in the current cycle.

module tb_multi_clock_divider;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
`ifdef CLKDIV_SYNC_EN
  logic              sync;
`endif
  logic [NUM_CH-1:0] en;
  logic              div_wr;
  logic [1:0]        div_sel;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] clk_out, tick, div_pend;

  typedef struct {
    int    cyc;
    int    ch;
    logic  co;
    logic  tk;
    logic  pd;
    string nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  multi_clock_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(3)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef CLKDIV_SYNC_EN
    .sync     (sync),
`endif
    .en       (en),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_val  (div_val),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_pend (div_pend)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int ch, input logic co, input logic tk,
                      input logic pd, input string nm);
    exp_t e;
    e.cyc = c; e.ch = ch; e.co = co; e.tk = tk; e.pd = pd; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input int val);
    div_wr  = 1'b1;
    div_sel = 2'(sel);
    div_val = CNT_W'(val);
  endtask

  // monitor: compare every expectation that falls due this cycle
  initial begin
    forever begin
      @(negedge clk);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          checks++;
          if ({clk_out[q[i].ch], tick[q[i].ch], div_pend[q[i].ch]} !== {q[i].co, q[i].tk, q[i].pd}) begin
            failures++;
            $display("FAIL %s cyc=%0d ch=%0d got clk_out/tick/pend=%b%b%b want=%b%b%b", q[i].nm, cyc,
                     q[i].ch, clk_out[q[i].ch], tick[q[i].ch], div_pend[q[i].ch], q[i].co, q[i].tk, q[i].pd);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = '0; div_wr = 1'b0; div_sel = '0; div_val = '0;
`ifdef CLKDIV_SYNC_EN
    sync = 1'b0;
`endif
    push(2, 0, 0, 0, 0, "rst"); push(2, 1, 0, 0, 0, "rst"); push(2, 2, 0, 0, 0, "rst");
    step(2);                                     // cyc 2
    checks++;
    if ({clk_out, tick, div_pend} !== '0) begin
      failures++;
      $display("FAIL rst_direct cyc=%0d clk_out=%b tick=%b pend=%b", cyc, clk_out, tick, div_pend);
    end
    rst = 1'b0; en = 3'b011;
    push(4, 0, 0, 0, 0, "cnt");   push(5, 0, 1, 1, 0, "tick1"); push(5, 1, 1, 1, 0, "tick1");
    push(6, 0, 1, 0, 0, "hi");    push(7, 0, 1, 0, 0, "hi");    push(8, 0, 0, 1, 0, "lo");
    push(8, 1, 0, 1, 0, "lo");    push(10, 0, 0, 0, 0, "lo");   push(11, 0, 1, 1, 0, "hi2");
    step(9);                                     // cyc 11
    wr(0, 4);
    push(12, 0, 1, 0, 1, "pend4"); push(14, 0, 0, 1, 0, "apply4");
    step(1);                                     // cyc 12
    checks++;
    if (div_pend[0] !== 1'b1) begin
      failures++;
      $display("FAIL pend_direct cyc=%0d pend=%b", cyc, div_pend);
    end
    wr(3, 7);
    push(13, 0, 1, 0, 1, "badsel"); push(13, 1, 1, 0, 0, "badsel"); push(13, 2, 0, 0, 0, "badsel");
    step(1);                                     // cyc 13
    div_wr = 1'b0;
    step(2);                                     // cyc 15
    wr(0, 2);
    push(16, 0, 0, 0, 1, "pend2"); push(17, 0, 0, 0, 1, "pend2"); push(18, 0, 1, 1, 0, "apply2");
    push(19, 0, 1, 0, 0, "h2");    push(20, 0, 0, 1, 0, "h2");    push(22, 0, 1, 1, 0, "h2");
    step(1);                                     // cyc 16
    wr(1, 0);
    push(17, 1, 1, 1, 1, "wr_at_tc"); push(19, 1, 1, 0, 1, "wr_at_tc"); push(20, 1, 0, 1, 0, "apply0");
    push(21, 1, 1, 1, 0, "div1");     push(22, 1, 0, 1, 0, "div1");     push(23, 1, 1, 1, 0, "div1");
    step(1);                                     // cyc 17
    div_wr = 1'b0;
    step(6);                                     // cyc 23
    en = 3'b010;
    push(24, 0, 1, 0, 0, "hold"); push(25, 1, 1, 1, 0, "div1"); push(26, 0, 1, 0, 0, "hold");
    push(28, 0, 1, 0, 0, "hold"); push(28, 1, 0, 1, 0, "div1"); push(29, 0, 0, 1, 0, "resume");
    step(5);                                     // cyc 28
    en = 3'b011;
    step(2);                                     // cyc 30
    en = 3'b010; wr(0, 5);
    push(31, 0, 0, 0, 1, "dis_pend"); push(32, 0, 0, 0, 0, "dis_apply");
    push(36, 0, 0, 0, 0, "c_clear");  push(37, 0, 1, 1, 0, "h5");
    step(1);                                     // cyc 31
    div_wr = 1'b0;
    step(1);                                     // cyc 32
    en = 3'b011;
    step(5);                                     // cyc 37
    wr(0, 7);
    push(39, 0, 1, 0, 1, "ovw_pend"); push(42, 0, 0, 1, 0, "ovw_tc");
    push(43, 0, 0, 0, 0, "ovw_h2");   push(44, 0, 1, 1, 0, "ovw_h2");
    step(1);                                     // cyc 38
    wr(0, 2);
    step(1);                                     // cyc 39
    div_wr = 1'b0;
    step(5);                                     // cyc 44
    wr(0, 3);
    push(45, 0, 1, 0, 1, "pend3");   push(46, 0, 0, 1, 1, "tc_wr_old"); push(47, 1, 1, 1, 0, "div1");
    push(48, 0, 0, 0, 1, "new_pend"); push(49, 0, 1, 1, 0, "old_h3");   push(52, 0, 1, 0, 0, "h4");
    push(53, 0, 0, 1, 0, "h4");
    step(1);                                     // cyc 45
    wr(0, 4);
    step(1);                                     // cyc 46
    div_wr = 1'b0;
    step(7);                                     // cyc 53
    wr(1, 9);
    push(54, 1, 0, 1, 1, "pend_rst");
    step(1);                                     // cyc 54
    rst = 1'b1; wr(0, 2);
    push(55, 0, 0, 0, 0, "rst_mid"); push(55, 1, 0, 0, 0, "rst_mid"); push(55, 2, 0, 0, 0, "rst_mid");
    step(1);                                     // cyc 55
    checks++;
    if ({clk_out, tick, div_pend} !== '0) begin
      failures++;
      $display("FAIL rst_mid_direct cyc=%0d clk_out=%b tick=%b pend=%b", cyc, clk_out, tick, div_pend);
    end
    rst = 1'b0; div_wr = 1'b0;
    push(57, 0, 0, 0, 0, "rst_h"); push(58, 0, 1, 1, 0, "rst_h"); push(58, 1, 1, 1, 0, "rst_h");
    push(61, 1, 0, 1, 0, "rst_h");
`ifdef CLKDIV_SYNC_EN
    step(6);                                     // cyc 61
    wr(1, 5);
    push(64, 1, 1, 1, 0, "h5b");
    step(1);                                     // cyc 62
    div_wr = 1'b0;
    step(9);                                     // cyc 71
    sync = 1'b1;
    push(72, 0, 0, 0, 0, "sync");    push(72, 1, 0, 0, 0, "sync");    push(74, 0, 0, 0, 0, "sync_h3");
    push(75, 0, 1, 1, 0, "sync_h3"); push(76, 1, 0, 0, 0, "sync_h5"); push(77, 1, 1, 1, 0, "sync_h5");
    step(1);                                     // cyc 72
    sync = 1'b0;
`endif
    step(10);
    foreach (q[i]) begin
      checks++;
      failures++;
      $display("FAIL %s never compared: due cyc=%0d ch=%0d, now cyc=%0d", q[i].nm, q[i].cyc, q[i].ch, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
